// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with busy scoreboard and optional write bypass
//
// Purpose: NUM_RD combinational read ports, one write port, x0 hardwired to zero,
//          and a per-register busy bit set at issue and cleared at writeback.
// Ports:
//    clk         rising-edge clock
//    rst_n       asynchronous active-low reset
//    rs_addr_i   read addresses, port k at [k*AW +: AW]
//    rs_data_o   read data, port k at [k*XLEN +: XLEN]
//    rs_ready_o  port k operand valid (not pending, or bypassed)
//    wr_en_i     writeback write enable
//    rd_addr_i   writeback address
//    rd_data_i   writeback data
//    issue_en_i  instruction issued with a destination
//    issue_rd_i  destination register of the issued instruction
//    busy_o      scoreboard vector, bit 0 always 0

module regfile_sb #(
   parameter int unsigned XLEN      = 64,
   parameter int unsigned NREGS     = 32,
   parameter int unsigned NUM_RD    = 2,
   parameter bit          BYPASS_EN = 1'b1,
   localparam int unsigned AW       = $clog2(NREGS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*AW-1:0]     rs_addr_i,
   output logic [NUM_RD*XLEN-1:0]   rs_data_o,
   output logic [NUM_RD-1:0]        rs_ready_o,
   input  logic                     wr_en_i,
   input  logic [AW-1:0]            rd_addr_i,
   input  logic [XLEN-1:0]          rd_data_i,
   input  logic                     issue_en_i,
   input  logic [AW-1:0]            issue_rd_i,
   output logic [NREGS-1:0]         busy_o
);

   // x0 has neither data storage nor a busy bit.
   logic [XLEN-1:0]  regs_q [1:NREGS-1];
   logic [NREGS-1:1] busy_q;
   logic [NREGS-1:1] busy_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 1; r < NREGS; r++) begin
            regs_q[r] <= '0;
         end
      end else if (wr_en_i && (rd_addr_i != '0)) begin
         regs_q[rd_addr_i] <= rd_data_i;
      end
   end

   // Set beats clear: a new producer issuing in the cycle the previous one
   // writes back must leave the register pending.
   always_comb begin
      busy_d = busy_q;
      for (int r = 1; r < NREGS; r++) begin
         if (issue_en_i && (issue_rd_i == AW'(r))) begin
            busy_d[r] = 1'b1;
         end else if (wr_en_i && (rd_addr_i == AW'(r))) begin
            busy_d[r] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_o = {busy_q, 1'b0};

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0]   addr;
      logic            byp;
      logic [XLEN-1:0] data;
      logic            rdy;

      assign addr = rs_addr_i[k*AW +: AW];
      assign byp  = BYPASS_EN && wr_en_i && (rd_addr_i == addr);

      // Bypassed data is by definition the completed result, so it is
      // ready even though the busy bit only drops at the next edge.
      always_comb begin
         data = '0;
         rdy  = 1'b1;
         if (addr == '0) begin
            data = '0;
            rdy  = 1'b1;
         end else if (byp) begin
            data = rd_data_i;
            rdy  = 1'b1;
         end else begin
            data = regs_q[addr];
            rdy  = !busy_q[addr];
         end
      end

      assign rs_data_o[k*XLEN +: XLEN] = data;
      assign rs_ready_o[k]             = rdy;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb, bypass and non-bypass instances

module tb_regfile_sb;

   logic         clk;
   logic         rst_n = 1'b1;
   logic [19:0]  rs_addr;
   logic         we;
   logic [4:0]   wa;
   logic [63:0]  wd;
   logic         ie;
   logic [4:0]   ir;

   logic [255:0] rs_data_b, rs_data_n;
   logic [3:0]   rs_ready_b, rs_ready_n;
   logic [31:0]  busy_b, busy_n;

   int checks;
   int failures;
   bit chk_on;

   regfile_sb #(.XLEN(64), .NREGS(32), .NUM_RD(4), .BYPASS_EN(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .rs_addr_i(rs_addr), .rs_data_o(rs_data_b),
      .rs_ready_o(rs_ready_b), .wr_en_i(we), .rd_addr_i(wa), .rd_data_i(wd),
      .issue_en_i(ie), .issue_rd_i(ir), .busy_o(busy_b)
   );

   regfile_sb #(.XLEN(64), .NREGS(32), .NUM_RD(4), .BYPASS_EN(1'b0)) dut_n (
      .clk(clk), .rst_n(rst_n), .rs_addr_i(rs_addr), .rs_data_o(rs_data_n),
      .rs_ready_o(rs_ready_n), .wr_en_i(we), .rd_addr_i(wa), .rd_data_i(wd),
      .issue_en_i(ie), .issue_rd_i(ir), .busy_o(busy_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural model
   logic [63:0] m_regs [32];
   logic [31:0] m_busy;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 64'h0;
      m_busy = 32'h0;
   endtask

   always @(negedge rst_n) model_reset();

   always @(posedge clk) begin
      if (rst_n === 1'b1) begin
         if (we && wa != 5'd0) m_regs[wa] = wd;
         if (we && wa != 5'd0 && !(ie && ir == wa)) m_busy[wa] = 1'b0;
         if (ie && ir != 5'd0) m_busy[ir] = 1'b1;
      end
   end

   function automatic logic [64:0] exp_port(input bit byp, input logic [4:0] a);
      if (a == 5'd0) return {1'b1, 64'h0};
      if (byp && we && wa == a) return {1'b1, wd};
      return {~m_busy[a], m_regs[a]};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         for (int k = 0; k < 4; k++) begin
            logic [4:0]  a;
            logic [64:0] e;
            a = rs_addr[k*5 +: 5];
            e = exp_port(1'b1, a);
            chk($sformatf("byp_data_p%0d", k), rs_data_b[k*64 +: 64], e[63:0]);
            chk($sformatf("byp_rdy_p%0d", k), 64'(rs_ready_b[k]), 64'(e[64]));
            e = exp_port(1'b0, a);
            chk($sformatf("nob_data_p%0d", k), rs_data_n[k*64 +: 64], e[63:0]);
            chk($sformatf("nob_rdy_p%0d", k), 64'(rs_ready_n[k]), 64'(e[64]));
         end
         chk("byp_busy", 64'(busy_b), 64'(m_busy));
         chk("nob_busy", 64'(busy_n), 64'(m_busy));
      end
   end

   task automatic rd4(input logic [4:0] a0, a1, a2, a3);
      rs_addr = {a3, a2, a1, a0};
   endtask

   task automatic idle();
      we = 1'b0;
      ie = 1'b0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [63:0] d);
      we = 1'b1;
      wa = a;
      wd = d;
   endtask

   task automatic iss(input logic [4:0] r);
      ie = 1'b1;
      ir = r;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      chk_on   = 1'b0;
      idle();
      wa = 5'd0;
      wd = 64'h0;
      ir = 5'd0;
      rd4(5'd0, 5'd0, 5'd0, 5'd0);
      model_reset();
      #1 rst_n = 1'b0;
      #2;
      chk("init_data", rs_data_b[63:0], 64'h0);
      chk("init_rdy", 64'(rs_ready_b), 64'hF);
      chk("init_busy", 64'(busy_n), 64'h0);
      tick();
      tick();
      rst_n  = 1'b1;
      chk_on = 1'b1;

      // x0: write and issue to x0 are ignored
      wr(5'd0, 64'h1234); iss(5'd0); rd4(5'd0, 5'd0, 5'd0, 5'd0);
      settle();
      chk("x0_data", rs_data_b[63:0], 64'h0);
      chk("x0_rdy", 64'(rs_ready_b[0]), 64'h1);
      tick();
      idle();
      settle();
      chk("x0_busy", 64'(busy_b), 64'h0);
      tick();

      // port independence
      wr(5'd1, 64'h1111);
      settle(); tick();
      wr(5'd2, 64'h2222);
      settle(); tick();
      idle(); rd4(5'd1, 5'd2, 5'd1, 5'd0);
      settle();
      chk("pi_p0", rs_data_n[63:0],    64'h1111);
      chk("pi_p1", rs_data_n[127:64],  64'h2222);
      chk("pi_p2", rs_data_n[191:128], 64'h1111);
      chk("pi_p3", rs_data_n[255:192], 64'h0);
      tick();

      // scoreboard: issue x7 at N, writeback at N+3
      iss(5'd7); rd4(5'd7, 5'd7, 5'd1, 5'd2);
      settle(); tick();
      idle();
      settle();
      chk("sb_busy7", 64'(busy_b[7]), 64'h1);
      chk("sb_rdy_b", 64'(rs_ready_b[0]), 64'h0);
      chk("sb_rdy_n", 64'(rs_ready_n[0]), 64'h0);
      tick();
      settle(); tick();
      wr(5'd7, 64'hAA);
      settle();
      chk("sb_byp_data", rs_data_b[63:0], 64'hAA);
      chk("sb_byp_rdy", 64'(rs_ready_b[0]), 64'h1);
      chk("sb_nob_data", rs_data_n[63:0], 64'h0);
      chk("sb_nob_rdy", 64'(rs_ready_n[0]), 64'h0);
      tick();
      idle();
      settle();
      chk("sb_busy7_clr", 64'(busy_b[7]), 64'h0);
      chk("sb_nob_data2", rs_data_n[63:0], 64'hAA);
      chk("sb_nob_rdy2", 64'(rs_ready_n[0]), 64'h1);
      tick();

      // simultaneous issue and writeback of a busy register
      iss(5'd9); rd4(5'd9, 5'd9, 5'd9, 5'd9);
      settle(); tick();
      iss(5'd9); wr(5'd9, 64'h99);
      settle(); tick();
      idle();
      settle();
      chk("sim_busy_b", 64'(busy_b[9]), 64'h1);
      chk("sim_busy_n", 64'(busy_n[9]), 64'h1);
      chk("sim_data", rs_data_n[63:0], 64'h99);
      chk("sim_rdy_b", 64'(rs_ready_b[0]), 64'h0);
      tick();
      wr(5'd9, 64'h9A);
      settle(); tick();

      // write visibility on all ports, non-busy register
      wr(5'd3, 64'h55); rd4(5'd3, 5'd3, 5'd3, 5'd3);
      settle();
      for (int k = 0; k < 4; k++) begin
         chk("wv_nob_old", rs_data_n[k*64 +: 64], 64'h0);
         chk("wv_byp_new", rs_data_b[k*64 +: 64], 64'h55);
      end
      tick();
      idle();
      settle();
      for (int k = 0; k < 4; k++) chk("wv_nob_new", rs_data_n[k*64 +: 64], 64'h55);
      tick();

      // write cycle of a busy register without bypass
      iss(5'd4); rd4(5'd4, 5'd4, 5'd4, 5'd4);
      settle(); tick();
      idle(); wr(5'd4, 64'h44);
      settle();
      chk("wb_nob_rdy", 64'(rs_ready_n[0]), 64'h0);
      chk("wb_byp_rdy", 64'(rs_ready_b[0]), 64'h1);
      tick();
      iss(5'd4); wr(5'd5, 64'hDEAD_BEEF);
      settle(); tick();

      // reset mid-cycle while a write to x6 is pending
      idle(); wr(5'd6, 64'h66); rd4(5'd5, 5'd5, 5'd5, 5'd5);
      settle();
      chk("pre_rst_x5", rs_data_n[63:0], 64'hDEAD_BEEF);
      chk("pre_rst_busy4", 64'(busy_n[4]), 64'h1);
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("rst_data_n", rs_data_n[k*64 +: 64], 64'h0);
         chk("rst_data_b", rs_data_b[k*64 +: 64], 64'h0);
      end
      chk("rst_rdy_n", 64'(rs_ready_n), 64'hF);
      chk("rst_rdy_b", 64'(rs_ready_b), 64'hF);
      chk("rst_busy_n", 64'(busy_n), 64'h0);
      chk("rst_busy_b", 64'(busy_b), 64'h0);
      tick();
      rst_n = 1'b1;
      idle(); rd4(5'd6, 5'd6, 5'd5, 5'd4);
      settle();
      chk("lost_x6", rs_data_n[63:0], 64'h0);
      chk("lost_x6_b", rs_data_b[127:64], 64'h0);
      tick();

      chk_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
